cycle_sequencer: RTL

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/seq_pkg.sv | 25 ++
 rtl/nmi_edge_latch.sv | 27 ++
 rtl/cycle_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared sequencing constants: microcode next-state codes and T-state numbers.
// Used by the cycle sequencer and the microcode ROM.
package seq_pkg;

  typedef enum logic [2:0] {
    NM_INC   = 3'd0,
    NM_END   = 3'd1,
    NM_ENDNC = 3'd2,
    NM_BR    = 3'd3,
    NM_BRX   = 3'd4,
    NM_BRT   = 3'd5,
    NM_KIL   = 3'd6,
    NM_RSV   = 3'd7
  } next_mode_e;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int T6 = 6;
  localparam int T7 = 7;

endpackage

// File: rtl/nmi_edge_latch.sv
// Detects a rising edge on the NMI source and holds it pending until taken.
// A new edge in the same cycle as a clear wins, so it is kept for the next boundary.
module nmi_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic edge_src,
  input  logic clear,
  output logic pending
);

  logic src_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_d   <= 1'b0;
      pending <= 1'b0;
    end else begin
      src_d <= edge_src;
      if (edge_src && !src_d) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// T-state sequencer: steps through instruction cycles under microcode control,
// counts cycles, samples interrupts at instruction boundaries and halts on KIL.
module cycle_sequencer
  import seq_pkg::*;
#(
  parameter int TW      = 3,
  parameter int TMAX    = 7,
  parameter int RESET_T = 2,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [2:0]    next_mode,
  input  logic          carry,
  input  logic          taken_branch,
  input  logic          page_cross,
  input  logic          force_t1,
  input  logic          force_t2,
  input  logic          force_t0,
  input  logic          irq_req,
  input  logic          irq_mask,
  input  logic          nmi_req,
  output logic [TW-1:0] t,
  output logic [TW-1:0] t_next,
  output logic          sync,
  output logic [CW-1:0] cycle_count,
  output logic          halted,
  output logic          overrun,
  output logic          int_take,
  output logic          int_nmi
);

  localparam logic [TW-1:0] TMAX_T  = TW'(TMAX);
  localparam logic [TW-1:0] RESET_V = TW'(RESET_T);
  localparam logic [TW-1:0] T0_V    = TW'(T0);
  localparam logic [TW-1:0] T1_V    = TW'(T1);
  localparam logic [TW-1:0] T2_V    = TW'(T2);

  next_mode_e    nm;
  logic [TW-1:0] t_q;
  logic          halted_q;
  logic [CW-1:0] cnt_q;
  logic          overrun_q;
  logic          int_take_q;
  logic          int_nmi_q;
  logic          overridden;
  logic          wrap;
  logic          kil_hit;
  logic          commit;
  logic          boundary;
  logic          nmi_pending;

  assign nm = next_mode_e'(next_mode);

  // Checked in simulation only; synthesis ignores assertions.
  param_legal_a: assert property (@(posedge clk) (TMAX < (1 << TW)) && (RESET_T <= TMAX));

  // State register: T-state and halt flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q      <= RESET_V;
      halted_q <= 1'b0;
    end else begin
      if (ready && kil_hit) begin
        halted_q <= 1'b1;
      end
      if (commit) begin
        t_q <= t_next;
      end
    end
  end

  // Next-state: forces lowest to highest, then the microcode code on top.
  always_comb begin
    t_next     = (t_q == TMAX_T) ? '0 : t_q + TW'(1);
    overridden = 1'b0;
    kil_hit    = 1'b0;
    if (force_t0) begin t_next = T0_V; overridden = 1'b1; end
    if (force_t2) begin t_next = T2_V; overridden = 1'b1; end
    if (force_t1) begin t_next = T1_V; overridden = 1'b1; end
    case (nm)
      NM_END:   begin t_next = T0_V; overridden = 1'b1; end
      NM_ENDNC: if (!carry) begin t_next = T0_V; overridden = 1'b1; end
      NM_BR:    if (!taken_branch) begin t_next = T1_V; overridden = 1'b1; end
      NM_BRX:   begin t_next = page_cross ? T0_V : T1_V; overridden = 1'b1; end
      NM_BRT:   if (!carry) begin t_next = T1_V; overridden = 1'b1; end
      NM_KIL:   kil_hit = (t_q != T1_V);
      default:  ;
    endcase
    wrap = (t_q == TMAX_T) && !overridden;
    if (halted_q) begin
      t_next  = t_q;
      kil_hit = 1'b0;
      wrap    = 1'b0;
    end
  end

  // A KIL edge freezes the machine in place rather than advancing it.
  assign commit   = ready && !halted_q && !kil_hit;
  assign boundary = commit && (t_next == T1_V);

  nmi_edge_latch u_nmi (
    .clk      (clk),
    .reset    (reset),
    .edge_src (nmi_req),
    .clear    (boundary && nmi_pending),
    .pending  (nmi_pending)
  );

  // Cycle counter, overrun flag and interrupt sampling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      int_take_q <= 1'b0;
      int_nmi_q  <= 1'b0;
    end else if (commit) begin
      if (wrap) begin
        overrun_q <= 1'b1;
      end
      if (boundary) begin
        cnt_q      <= '0;
        int_nmi_q  <= nmi_pending;
        int_take_q <= nmi_pending || (irq_req && !irq_mask);
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Outputs.
  always_comb begin
    t           = t_q;
    halted      = halted_q;
    sync        = (t_q == T1_V) && !halted_q;
    cycle_count = cnt_q;
    overrun     = overrun_q;
    int_take    = int_take_q && !halted_q;
    int_nmi     = int_nmi_q;
  end

endmodule
